perf_monitor: RTL and testbench
===============================

# perf_monitor

Cycle-accounting block for the accelerator datapath. It counts total, busy and idle clock cycles while enabled, and it periodically computes integer percent utilization (busy/total × 100) with an iterative divider. It sits beside the compute core: it observes the core's `busy` flag and exposes its counters to the status/CSR logic.

## Interface
- `COUNTER_WIDTH`, default 32: width of every counter and of `utilization`; legal range 8..32.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset (0 = in reset); asserts immediately, deassertion is synchronised externally.
- `enable` input 1: counting enable; counters advance only when 1.
- `clear` input 1: synchronous clear of counters and divider; has priority over `enable`.
- `busy` input 1: core-busy flag, sampled each rising edge.
- `total_cycles` output COUNTER_WIDTH: enabled cycles since reset/clear.
- `busy_cycles` output COUNTER_WIDTH: enabled cycles with `busy`=1.
- `idle_cycles` output COUNTER_WIDTH: enabled cycles with `busy`=0.
- `utilization` output COUNTER_WIDTH: floor(100 × busy/total), range 0..100, zero-extended.

## Operation
- Reset (`reset`=0): all four outputs are 0, and the divider goes to LOAD with internal registers at 0.
- `clear`=1 at an edge: same effect as reset, applied synchronously. Overrides `enable`.
- `enable`=1, `clear`=0, not saturated: `total_cycles`+1, plus `busy_cycles`+1 if `busy`=1, else `idle_cycles`+1.
- Invariant at all times: `busy_cycles` + `idle_cycles` = `total_cycles`.
- Saturation: when `total_cycles` reaches all-ones, all three counters freeze. They never wrap. Only reset or clear resumes counting.
- `enable`=0: counters hold, and the divider keeps running.
- Divider FSM, two states:
  - LOAD: snapshot numerator N = `busy_cycles`×100 (COUNTER_WIDTH+7 bits) and denominator D = `total_cycles`. Clear the quotient and remainder, then go to DIV.
  - DIV: restoring radix-2 division, one quotient bit per cycle, MSB first, for exactly COUNTER_WIDTH+7 cycles.
  - On the final DIV cycle, write the quotient to `utilization` and return to LOAD.
- If D = 0, the result written is 0.
- Quotient is at most 100. The 7 LSBs are written and the upper bits are zero.
- Snapshot semantics: `utilization` reflects counters as of the most recent LOAD. Counter changes during DIV affect only the next result.

## Timing
- Counter update latency: 1 cycle. The output reflects `busy`/`enable` sampled at the same edge.
- Divider period P = COUNTER_WIDTH+8 cycles (40 for the default). This is 1 LOAD cycle plus COUNTER_WIDTH+7 DIV cycles, free-running from reset release.
- `utilization` changes only on the last DIV cycle of each period.
- Worst-case staleness of `utilization` relative to the counters: 2P−1 cycles.
- After the counters stop changing (`enable`=0), `utilization` is correct within 2P cycles.
- Reset or clear mid-division aborts the division. `utilization` becomes 0, and the next period starts from LOAD.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
- Reset: hold `reset`=0 with `busy`/`enable` toggling -> all outputs 0. Release, then keep `enable`=0 for 100 cycles -> outputs stay 0 and `utilization` stays 0 (D=0).
- Mixed load: after reset, `enable`=1 for 150 cycles with `busy`=1 on 50 of them (any pattern), then `enable`=0 and wait 80 cycles -> total 150, busy 50, idle 100, utilization 33.
- Full and alternating: 64 enabled cycles, all busy, then wait 2P -> utilization 100. Clear, then 200 enabled cycles alternating busy -> busy 100, idle 100, utilization 50.
- Enable gating and clear priority: `enable`=0 with `busy`=1 for 30 cycles -> counters unchanged. `clear`=1 and `enable`=1 at the same edge -> all counters 0 the next cycle.
- Mid-division reset: assert `reset`=0 for one cycle mid-period -> outputs 0 immediately (asynchronous). After 60 enabled cycles with 15 busy, then `enable`=0 and waiting 2P -> utilization 25.
- Saturation with COUNTER_WIDTH=8: 300 enabled cycles, all busy -> total 255, busy 255, idle 0, frozen; utilization 100. Clear, then 255 idle cycles -> utilization 0.

Source files
------------

// File: rtl/perf_monitor.sv
// Cycle accounting for the accelerator core: total/busy/idle counters plus a
// free-running restoring divider that periodically reports percent utilization.
module perf_monitor #(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_enable,
    input  logic                     i_clear,
    input  logic                     i_busy,
    output logic [COUNTER_WIDTH-1:0] o_total_cycles,
    output logic [COUNTER_WIDTH-1:0] o_busy_cycles,
    output logic [COUNTER_WIDTH-1:0] o_idle_cycles,
    output logic [COUNTER_WIDTH-1:0] o_utilization
);

    localparam int NW   = COUNTER_WIDTH + 7;
    localparam int CNTW = $clog2(NW);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
    localparam logic [CNTW-1:0]          STEP_ONE = CNTW'(1);
    localparam logic [CNTW-1:0]          STEP_LAST = CNTW'(NW - 1);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_DIV  = 1'b1
    } state_t;

    logic [COUNTER_WIDTH-1:0] r_total;
    logic [COUNTER_WIDTH-1:0] r_busy;
    logic [COUNTER_WIDTH-1:0] r_idle;
    logic                     w_saturated;

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     w_load;
    logic                     w_step;
    logic                     w_last;

    logic [NW-1:0]            r_num;
    logic [COUNTER_WIDTH-1:0] r_den;
    logic [COUNTER_WIDTH-1:0] r_rem;
    logic [6:0]               r_quo;
    logic [CNTW-1:0]          r_cnt;
    logic [6:0]               r_util;

    logic [NW-1:0]            w_num;
    logic [COUNTER_WIDTH:0]   w_rem_shift;
    logic [COUNTER_WIDTH-1:0] w_rem_sub;
    logic                     w_ge;
    logic [6:0]               w_quo_next;

    // Counters freeze once total hits all-ones so the ratio never wraps.
    assign w_saturated = &r_total;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_total <= '0;
            r_busy  <= '0;
            r_idle  <= '0;
        end else if (i_clear) begin
            r_total <= '0;
            r_busy  <= '0;
            r_idle  <= '0;
        end else if (i_enable && !w_saturated) begin
            r_total <= r_total + CNT_ONE;
            if (i_busy) begin
                r_busy <= r_busy + CNT_ONE;
            end else begin
                r_idle <= r_idle + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_LOAD;
        end else if (i_clear) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD:  w_state_next = S_DIV;
            S_DIV:   if (r_cnt == STEP_LAST) w_state_next = S_LOAD;
            default: w_state_next = S_LOAD;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_last = 1'b0;
        case (r_state)
            S_LOAD: w_load = 1'b1;
            S_DIV: begin
                w_step = 1'b1;
                w_last = (r_cnt == STEP_LAST);
            end
            default: w_load = 1'b1;
        endcase
    end

    // Restoring step: remainder is always below the denominator, so the
    // difference fits back into COUNTER_WIDTH bits.
    assign w_num       = {7'd0, r_busy} * NW'(100);
    assign w_rem_shift = {r_rem, r_num[NW-1]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_den});
    assign w_rem_sub   = w_rem_shift[COUNTER_WIDTH-1:0] - r_den;
    assign w_quo_next  = {r_quo[5:0], w_ge};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_num  <= '0;
            r_den  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_util <= '0;
        end else if (i_clear) begin
            r_num  <= '0;
            r_den  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_util <= '0;
        end else if (w_load) begin
            r_num <= w_num;
            r_den <= r_total;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_num <= {r_num[NW-2:0], 1'b0};
            r_rem <= w_ge ? w_rem_sub : w_rem_shift[COUNTER_WIDTH-1:0];
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + STEP_ONE;
            // Quotient never exceeds 100, so 7 bits carry the whole result.
            if (w_last) begin
                r_util <= (r_den == '0) ? 7'd0 : w_quo_next;
            end
        end
    end

    assign o_total_cycles = r_total;
    assign o_busy_cycles  = r_busy;
    assign o_idle_cycles  = r_idle;
    assign o_utilization  = {{(COUNTER_WIDTH-7){1'b0}}, r_util};

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a 32-bit and an 8-bit instance share the
// same stimulus; the 8-bit one covers saturation.
module tb_perf_monitor;

    localparam int W32 = 32;
    localparam int W8  = 8;
    localparam int P32 = W32 + 8;
    localparam int P8  = W8 + 8;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic clear;
    logic busy;

    logic [W32-1:0] t32, b32, i32, u32;
    logic [W8-1:0]  t8, b8, i8, u8;

    int n_compared = 0;
    int n_mismatch = 0;

    always #5 clk = ~clk;

    perf_monitor #(.COUNTER_WIDTH(W32)) u_dut32 (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_clear        (clear),
        .i_busy         (busy),
        .o_total_cycles (t32),
        .o_busy_cycles  (b32),
        .o_idle_cycles  (i32),
        .o_utilization  (u32)
    );

    perf_monitor #(.COUNTER_WIDTH(W8)) u_dut8 (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_clear        (clear),
        .i_busy         (busy),
        .o_total_cycles (t8),
        .o_busy_cycles  (b8),
        .o_idle_cycles  (i8),
        .o_utilization  (u8)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic check_counts32(input string tag, input int t, input int b, input int i);
        check_value({tag, " total"}, t32, 32'(t));
        check_value({tag, " busy"},  b32, 32'(b));
        check_value({tag, " idle"},  i32, 32'(i));
    endtask

    task automatic check_counts8(input string tag, input int t, input int b, input int i);
        check_value({tag, " total8"}, 32'(t8), 32'(t));
        check_value({tag, " busy8"},  32'(b8), 32'(b));
        check_value({tag, " idle8"},  32'(i8), 32'(i));
    endtask

    // n cycles with the given enable; busy high on the first nbusy cycles,
    // or on every odd cycle when alt is set. Starts and ends on a negedge.
    task automatic drive(input int n, input logic en, input int nbusy, input bit alt);
        for (int k = 0; k < n; k++) begin
            enable = en;
            busy   = alt ? (k % 2 == 1) : (k < nbusy);
            @(negedge clk);
        end
        enable = 1'b0;
        busy   = 1'b0;
    endtask

    task automatic pulse_clear(input logic en);
        clear  = 1'b1;
        enable = en;
        busy   = 1'b1;
        @(negedge clk);
        clear  = 1'b0;
        enable = 1'b0;
        busy   = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        clear  = 1'b0;
        busy   = 1'b1;

        // Reset held while inputs toggle
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            enable = ~enable;
            busy   = (k % 3 == 0);
        end
        check_counts32("reset", 0, 0, 0);
        check_value("reset util", u32, 32'd0);
        check_value("reset total8", 32'(t8), 32'd0);

        enable = 1'b0;
        busy   = 1'b0;
        rst_n  = 1'b1;
        drive(100, 1'b0, 0, 1'b0);
        check_counts32("idle after reset", 0, 0, 0);
        check_value("idle util D=0", u32, 32'd0);

        // Mixed load: 150 enabled, 50 busy -> 5000/150 = 33
        drive(150, 1'b1, 50, 1'b0);
        check_counts32("mixed", 150, 50, 100);
        drive(2 * P32, 1'b0, 0, 1'b0);
        check_value("mixed util", u32, 32'd33);
        check_counts32("mixed hold", 150, 50, 100);

        // All busy -> 100
        pulse_clear(1'b0);
        check_counts32("clear", 0, 0, 0);
        drive(64, 1'b1, 64, 1'b0);
        drive(2 * P32, 1'b0, 0, 1'b0);
        check_counts32("full", 64, 64, 0);
        check_value("full util", u32, 32'd100);

        // Alternating -> 50
        pulse_clear(1'b0);
        check_value("clear util", u32, 32'd0);
        drive(200, 1'b1, 0, 1'b1);
        check_counts32("alt", 200, 100, 100);
        drive(2 * P32, 1'b0, 0, 1'b0);
        check_value("alt util", u32, 32'd50);

        // Enable gating with busy high
        for (int k = 0; k < 30; k++) begin
            enable = 1'b0;
            busy   = 1'b1;
            @(negedge clk);
        end
        busy = 1'b0;
        check_counts32("gated", 200, 100, 100);
        check_value("gated util", u32, 32'd50);

        // Clear wins over enable at the same edge
        pulse_clear(1'b1);
        check_counts32("clear prio", 0, 0, 0);
        check_value("clear prio util", u32, 32'd0);

        // Build a nonzero utilization, then reset asynchronously mid-period
        drive(20, 1'b1, 20, 1'b0);
        drive(2 * P32, 1'b0, 0, 1'b0);
        check_value("pre-reset util", u32, 32'd100);
        drive(13, 1'b0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("async rst total", t32, 32'd0);
        check_value("async rst util", u32, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(60, 1'b1, 15, 1'b0);
        drive(2 * P32, 1'b0, 0, 1'b0);
        check_counts32("post-reset", 60, 15, 45);
        check_value("post-reset util", u32, 32'd25);

        // Saturation on the 8-bit instance
        pulse_clear(1'b0);
        drive(300, 1'b1, 300, 1'b0);
        check_counts8("sat", 255, 255, 0);
        drive(2 * P8, 1'b0, 0, 1'b0);
        check_value("sat util8", 32'(u8), 32'd100);
        drive(5, 1'b1, 5, 1'b0);
        check_counts8("sat frozen", 255, 255, 0);

        pulse_clear(1'b0);
        drive(255, 1'b1, 0, 1'b0);
        check_counts8("sat idle", 255, 0, 255);
        drive(2 * P8, 1'b0, 0, 1'b0);
        check_value("sat idle util8", 32'(u8), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
